vram_spi_writer: RTL and testbench
==================================

VRAM_SPI_WRITER -- requirements
Module: vram_spi_writer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16: VRAM word-address width of a FIFO entry.
REQ-002 Parameter DATA_WIDTH, default 16: VRAM word width; fixed at 16 for this block.
REQ-003 Parameter COUNT_WIDTH, default 3: width of the FIFO occupancy input.
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 fifo_items_count  input  COUNT_WIDTH: write-FIFO occupancy.
REQ-007 fifo_read_request  output  1: one-cycle pop strobe to the write FIFO.
REQ-008 fifo_read_address  input  ADDRESS_WIDTH: popped entry address, valid the cycle after the pop strobe.
REQ-009 fifo_read_data  input  DATA_WIDTH: popped entry data, same timing as the address.
REQ-010 bus_request  output  1: requests the shared SPI SRAM bus from the arbiter.
REQ-011 bus_grant  input  1: arbiter grant; sampled only in REQ.
REQ-012 spi_cs_n  output  1: SRAM chip select, active low.
REQ-013 spi_sck  output  1: SPI clock, mode 0, frequency clk/2.
REQ-014 spi_sio_out  output  1: serial data to the SRAM, MSB first.
REQ-015 busy  output  1: high in every state except IDLE.
REQ-016 write_done  output  1: one-cycle pulse when a transaction's last bit has been clocked.

Function
REQ-017 The FSM SHALL have states IDLE, POP, LATCH, REQ, SHIFT, GAP.
REQ-018 IDLE -> POP when fifo_items_count != 0; otherwise stay in IDLE.
REQ-019 POP SHALL assert fifo_read_request for exactly one cycle, then -> LATCH.
REQ-020 LATCH SHALL capture fifo_read_address/fifo_read_data into the shift register at the end of its cycle, then -> REQ.
REQ-021 At most one pop SHALL be outstanding; no pop outside POP.
REQ-022 REQ SHALL hold bus_request high and -> SHIFT on the first cycle bus_grant=1; it waits indefinitely otherwise.
REQ-023 bus_request SHALL stay high from REQ through the end of GAP and drop on the return to IDLE.
REQ-024 Frame: 48 bits = command 8'h02, 24-bit byte address {(23-ADDRESS_WIDTH) zeros, address, 1'b0}, then 16 data bits.
REQ-025 In SHIFT, spi_cs_n=0; each bit occupies 2 clk cycles: sck low (sio_out updated), then sck high.
REQ-026 SHIFT SHALL last exactly 96 cycles; a 6-bit counter tracks bits 0..47.
REQ-027 On leaving SHIFT: sck=0, cs_n=1, write_done=1 for one cycle, -> GAP.
REQ-028 GAP SHALL hold cs_n high for 2 cycles, then -> IDLE.
REQ-029 Throughput: minimum 1+1+1+1+96+2 = 102 cycles per entry, grant permitting.
REQ-030 Outside SHIFT: spi_sck=0, spi_cs_n=1, spi_sio_out=0.
REQ-031 bus_grant deassertion during SHIFT or GAP SHALL be ignored; a frame is never aborted.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, spi_cs_n=1, spi_sck=0, spi_sio_out=0, bus_request=0, fifo_read_request=0, busy=0, write_done=0, and clear the bit counter and shift register.
REQ-034 Reset mid-SHIFT SHALL abort the frame; the FIFO entry is lost, with no retry.
REQ-035 Deassertion of reset_n SHALL take effect at the next rising clk edge; the first pop occurs no earlier than 1 cycle after it.

Configuration
REQ-036 Macro VRAM_WRITER_STATS_EN: when defined, adds output writes_completed [15:0], reset to 0, incremented on each write_done and wrapping 16'hFFFF -> 0.
REQ-037 When VRAM_WRITER_STATS_EN is undefined, the writes_completed port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 count=1, address 16'h1234, data 16'hABCD, grant tied high -> frame bits 02 00 24 68 AB CD; cs_n low for 96 cycles; one write_done.
REQ-039 count=3, three entries, grant high -> 3 pops, 3 frames, each separated by 2 cycles of cs_n high plus IDLE/POP/LATCH/REQ; exactly 3 write_done pulses.
REQ-040 Entry pending, grant held low 50 cycles -> bus_request high and cs_n high throughout; first SCK edge follows the grant.
REQ-041 reset_n=0 at frame bit 20 -> cs_n=1 and sck=0 asynchronously; busy=0; after release with count=0 -> stays IDLE.
REQ-042 count=0 for 200 cycles -> fifo_read_request never asserted; bus_request=0.
REQ-043 With VRAM_WRITER_STATS_EN defined: 65537 frames -> writes_completed=1.

Source files
------------

// File: rtl/vram_spi_writer.sv
// vram_spi_writer: drains a VRAM write FIFO one entry at a time and writes
// each entry to an SPI SRAM (mode 0, sck = clk/2) as a 48-bit WRITE frame:
// command 8'h02, 24-bit byte address, 16 data bits, MSB first.
// Optional build macro VRAM_WRITER_STATS_EN adds the writes_completed counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a non-empty FIFO
// ST_POP   | one-cycle pop strobe to the FIFO
// ST_LATCH | popped entry is valid; load it into the shift register
// ST_REQ   | bus_request high, waiting for bus_grant
// ST_SHIFT | cs_n low, 48 bits clocked out at 2 clk per bit
// ST_GAP   | two cycles of cs_n high before returning to idle
module vram_spi_writer #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int COUNT_WIDTH   = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [COUNT_WIDTH-1:0]   fifo_items_count,
   output logic                     fifo_read_request,
   input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
   input  logic [DATA_WIDTH-1:0]    fifo_read_data,
   output logic                     bus_request,
   input  logic                     bus_grant,
   output logic                     spi_cs_n,
   output logic                     spi_sck,
   output logic                     spi_sio_out,
   output logic                     busy,
`ifdef VRAM_WRITER_STATS_EN
   output logic [15:0]              writes_completed,
`endif
   output logic                     write_done
);

   localparam int FRAME_BITS = 48;
   localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LATCH,
      ST_REQ,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t                  state;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic [5:0]              bit_cnt;
   logic                    gap_cnt;
   logic [FRAME_BITS-1:0]   frame_word;
   logic                    frame_end;

   // WRITE command, word address turned into a byte address, then data.
   assign frame_word = {8'h02, {(23-ADDRESS_WIDTH){1'b0}}, fifo_read_address,
                        1'b0, fifo_read_data};

   // Last high phase of the last bit: the frame closes on this edge.
   assign frame_end = (state == ST_SHIFT) && spi_sck && (bit_cnt == LAST_BIT);

   // Sequencer with all outputs registered from the next-state decision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         shift_reg         <= '0;
         bit_cnt           <= '0;
         gap_cnt           <= 1'b0;
         fifo_read_request <= 1'b0;
         bus_request       <= 1'b0;
         spi_cs_n          <= 1'b1;
         spi_sck           <= 1'b0;
         spi_sio_out       <= 1'b0;
         busy              <= 1'b0;
         write_done        <= 1'b0;
      end else begin
         fifo_read_request <= 1'b0;
         write_done        <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fifo_items_count != '0) begin
                  state             <= ST_POP;
                  fifo_read_request <= 1'b1;
                  busy              <= 1'b1;
               end
            end
            ST_POP: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               shift_reg   <= frame_word;
               bus_request <= 1'b1;
               state       <= ST_REQ;
            end
            ST_REQ: begin
               if (bus_grant) begin
                  state       <= ST_SHIFT;
                  spi_cs_n    <= 1'b0;
                  spi_sck     <= 1'b0;
                  spi_sio_out <= shift_reg[FRAME_BITS-1];
                  bit_cnt     <= '0;
               end
            end
            ST_SHIFT: begin
               if (!spi_sck) begin
                  spi_sck <= 1'b1;
               end else if (bit_cnt == LAST_BIT) begin
                  state       <= ST_GAP;
                  spi_sck     <= 1'b0;
                  spi_cs_n    <= 1'b1;
                  spi_sio_out <= 1'b0;
                  write_done  <= 1'b1;
                  gap_cnt     <= 1'b0;
                  bit_cnt     <= '0;
               end else begin
                  bit_cnt     <= bit_cnt + 6'd1;
                  spi_sck     <= 1'b0;
                  spi_sio_out <= shift_reg[FRAME_BITS-2];
                  shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
               end
            end
            ST_GAP: begin
               if (gap_cnt) begin
                  state       <= ST_IDLE;
                  bus_request <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  gap_cnt <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               bus_request <= 1'b0;
               spi_cs_n    <= 1'b1;
               spi_sck     <= 1'b0;
               spi_sio_out <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

`ifdef VRAM_WRITER_STATS_EN
   // Completed-frame counter, stepping on the same edge that raises write_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         writes_completed <= '0;
      else if (frame_end)
         writes_completed <= writes_completed + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vram_spi_writer.sv
// Bench for vram_spi_writer: FIFO model, SPI frame decoder and directed plus
// randomized scenarios.
`timescale 1ns/1ps
module tb_vram_spi_writer;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [CW-1:0] fifo_items_count;
   logic          fifo_read_request;
   logic [AW-1:0] fifo_read_address;
   logic [DW-1:0] fifo_read_data;
   logic          bus_request;
   logic          bus_grant;
   logic          spi_cs_n, spi_sck, spi_sio_out, busy, write_done;
`ifdef VRAM_WRITER_STATS_EN
   logic [15:0]   writes_completed;
`endif

   vram_spi_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .fifo_items_count(fifo_items_count),
      .fifo_read_request(fifo_read_request),
      .fifo_read_address(fifo_read_address),
      .fifo_read_data(fifo_read_data),
      .bus_request(bus_request), .bus_grant(bus_grant),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_sio_out(spi_sio_out),
      .busy(busy),
`ifdef VRAM_WRITER_STATS_EN
      .writes_completed(writes_completed),
`endif
      .write_done(write_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      logic [47:0] f;
   } entry_t;

   entry_t      vec [7];
   entry_t      fifo_q [$];
   logic [47:0] exp_q [$];

   int total = 0;
   int bad = 0;
   int viol = 0;
   int frames = 0;
   int wd_count = 0;
   int rr_count = 0;
   int br_cycles = 0;
   int last_gap = 0;
   int mon_nbits = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame the SRAM should see: WRITE opcode, byte address = 2 * word address, data.
   function automatic logic [47:0] expect_frame(input logic [15:0] a, input logic [15:0] d);
      return (48'h02 << 40) + (48'(a) * 48'd2 << 16) + 48'(d);
   endfunction

   // Write-FIFO model: pops on the strobe, presents the entry for the next cycle.
   initial begin
      entry_t e;
      fifo_items_count  = '0;
      fifo_read_address = '0;
      fifo_read_data    = '0;
      forever begin
         @(negedge clk);
         if (reset_n && fifo_read_request) begin
            rr_count++;
            if (fifo_q.size() == 0) begin
               viol++;
            end else begin
               e = fifo_q.pop_front();
               fifo_read_address = e.a;
               fifo_read_data    = e.d;
               exp_q.push_back(e.f);
            end
         end
         fifo_items_count = (fifo_q.size() > 7) ? 3'd7 : 3'(fifo_q.size());
      end
   end

   // SPI decoder and per-cycle protocol invariants.
   initial begin
      logic [47:0] bits;
      logic        prev_cs, prev_sck, prev_rr;
      int          low, high_run;
      bits = '0; prev_cs = 1'b1; prev_sck = 1'b0; prev_rr = 1'b0;
      low = 0; high_run = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            bits = '0; mon_nbits = 0; low = 0; high_run = 0;
            prev_cs = 1'b1; prev_sck = 1'b0; prev_rr = 1'b0;
         end else begin
            if (spi_cs_n && (spi_sck || spi_sio_out)) viol++;
            if (fifo_read_request && prev_rr) viol++;
            if (!busy && (bus_request || !spi_cs_n || fifo_read_request)) viol++;
            if (!spi_cs_n && !bus_request) viol++;
            if (write_done) wd_count++;
            if (bus_request) br_cycles++;
            if (!spi_cs_n) begin
               low++;
               if (spi_sck && !prev_sck) begin
                  bits = {bits[46:0], spi_sio_out};
                  mon_nbits++;
               end
            end
            if (!spi_cs_n && prev_cs) last_gap = high_run;
            high_run = spi_cs_n ? high_run + 1 : 0;
            if (spi_cs_n && !prev_cs) begin
               frames++;
               chk("frame_cs_low_cycles", 64'(low), 64'd96);
               chk("frame_bit_count", 64'(mon_nbits), 64'd48);
               chk("write_done_at_frame_end", 64'(write_done), 64'd1);
               if (exp_q.size() == 0)
                  chk("frame_without_pop", 64'd1, 64'd0);
               else
                  chk("frame_contents", 64'(bits), 64'(exp_q.pop_front()));
               low = 0; mon_nbits = 0;
            end
            prev_cs  = spi_cs_n;
            prev_sck = spi_sck;
            prev_rr  = fifo_read_request;
         end
      end
   end

   task automatic wait_frames(input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (frames >= target) return;
      end
      chk(name, 64'(frames), 64'(target));
   endtask

   initial begin
      entry_t e;
      int f0, wd0, rr0, br0, bad_cycles;

      vec[0] = '{16'h1234, 16'hABCD, 48'h02002468ABCD};
      vec[1] = '{16'hFFFF, 16'h0000, 48'h0201FFFE0000};
      vec[2] = '{16'h0000, 16'hFFFF, 48'h02000000FFFF};
      vec[3] = '{16'h8001, 16'h5A5A, 48'h020100025A5A};
      vec[4] = '{16'h0001, 16'h8000, 48'h020000028000};
      vec[5] = '{16'h7FFE, 16'h0001, 48'h0200FFFC0001};
      vec[6] = '{16'h4000, 16'h1357, 48'h020080001357};

      bus_grant = 1'b1;
      reset_n   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cs_n", 64'(spi_cs_n), 64'd1);
      chk("reset_sck", 64'(spi_sck), 64'd0);
      chk("reset_sio", 64'(spi_sio_out), 64'd0);
      chk("reset_bus_request", 64'(bus_request), 64'd0);
      chk("reset_read_request", 64'(fifo_read_request), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_write_done", 64'(write_done), 64'd0);
      reset_n = 1'b1;

      // Empty FIFO: nothing must move.
      rr0 = rr_count; br0 = br_cycles;
      repeat (200) @(negedge clk);
      chk("idle_no_pop", 64'(rr_count - rr0), 64'd0);
      chk("idle_no_bus_request", 64'(br_cycles - br0), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      // Single entries from the table, one at a time.
      for (int i = 0; i < 4; i++) begin
         f0 = frames; wd0 = wd_count;
         fifo_q.push_back(vec[i]);
         wait_frames(f0 + 1, 400, "single_frame_timeout");
         repeat (5) @(negedge clk);
         chk("single_write_done_count", 64'(wd_count - wd0), 64'd1);
         chk("single_back_to_idle", 64'(busy), 64'd0);
      end

      // Three entries queued at once: back-to-back frames with a 6-cycle cs_n gap.
      f0 = frames; wd0 = wd_count; rr0 = rr_count;
      for (int i = 4; i < 7; i++) fifo_q.push_back(vec[i]);
      wait_frames(f0 + 1, 400, "burst_frame1_timeout");
      wait_frames(f0 + 2, 400, "burst_frame2_timeout");
      chk("burst_gap_before_frame2", 64'(last_gap), 64'd6);
      wait_frames(f0 + 3, 400, "burst_frame3_timeout");
      chk("burst_gap_before_frame3", 64'(last_gap), 64'd6);
      repeat (5) @(negedge clk);
      chk("burst_write_done_count", 64'(wd_count - wd0), 64'd3);
      chk("burst_pop_count", 64'(rr_count - rr0), 64'd3);

      // Grant withheld: request stays up, chip select stays high, frame follows the grant.
      f0 = frames;
      bus_grant = 1'b0;
      fifo_q.push_back('{16'hC0DE, 16'hBEEF, expect_frame(16'hC0DE, 16'hBEEF)});
      repeat (6) @(negedge clk);
      bad_cycles = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus_request || !spi_cs_n || spi_sck) bad_cycles++;
      end
      chk("no_grant_hold_cycles_bad", 64'(bad_cycles), 64'd0);
      bus_grant = 1'b1;
      @(negedge clk);
      chk("cs_low_after_grant", 64'(spi_cs_n), 64'd0);
      repeat (10) @(negedge clk);
      bus_grant = 1'b0;               // must not abort the frame
      wait_frames(f0 + 1, 400, "grant_frame_timeout");
      chk("bus_request_held_in_gap", 64'(bus_request), 64'd1);
      bus_grant = 1'b1;
      repeat (5) @(negedge clk);

      // Reset in the middle of a frame.
      f0 = frames; rr0 = rr_count;
      fifo_q.push_back('{16'h0F0F, 16'h3C3C, expect_frame(16'h0F0F, 16'h3C3C)});
      begin
         int k;
         for (k = 0; k < 400; k++) begin
            @(posedge clk);
            if (mon_nbits >= 20) break;
         end
         if (k == 400) chk("reset_test_bit20_timeout", 64'(mon_nbits), 64'd20);
      end
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_cs_n", 64'(spi_cs_n), 64'd1);
      chk("async_reset_sck", 64'(spi_sck), 64'd0);
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_bus_request", 64'(bus_request), 64'd0);
      exp_q.delete();                  // the aborted entry is gone
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("after_reset_stays_idle", 64'(busy), 64'd0);
      chk("after_reset_no_pop", 64'(rr_count - rr0), 64'd1);
      chk("after_reset_no_frame", 64'(frames - f0), 64'd0);

      // Randomized entries with a flickering grant.
      f0 = frames;
      for (int i = 0; i < 20; i++) begin
         e.a = 16'($urandom);
         e.d = 16'($urandom);
         e.f = expect_frame(e.a, e.d);
         fifo_q.push_back(e);
      end
      begin
         int k;
         for (k = 0; k < 8000; k++) begin
            @(negedge clk);
            bus_grant = ($urandom_range(0, 3) != 0);
            if (frames >= f0 + 20) break;
         end
         if (k == 8000) chk("random_timeout", 64'(frames - f0), 64'd20);
      end
      bus_grant = 1'b1;
      repeat (10) @(negedge clk);

      chk("write_done_matches_frames", 64'(wd_count), 64'(frames));
      chk("protocol_violations", 64'(viol), 64'd0);
      chk("fifo_drained", 64'(fifo_q.size()), 64'd0);
      chk("no_unsent_entries", 64'(exp_q.size()), 64'd0);
`ifdef VRAM_WRITER_STATS_EN
      // Counter survived the mid-frame reset only for frames after it.
      chk("writes_completed", 64'(writes_completed), 64'(frames - f0));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
